// File: rtl/pam4_prbs_tx.sv
// PAM4 test-pattern transmitter: alternating full-scale preamble followed by a
// PRBS-derived symbol stream, presented as symbol, signed level and scaled sample.
module pam4_prbs_tx #(
  parameter int          PRBS_ORDER = 7,
  parameter logic [14:0] SEED       = 15'h7FFF,
  parameter int          PRE_LEN    = 8,
  parameter bit          GRAY       = 1'b0,
  parameter int          AMP        = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic [15:0]       i_len,
  input  logic              i_abort,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [1:0]        o_d_sym,
  output logic signed [3:0] o_d_lvl,
  output logic signed [7:0] o_s_out,
  output logic              o_sof,
  output logic              o_eof,
  output logic              o_busy,
  output logic              o_done,
  output logic [1:0]        o_state
);

  // Handshake: a symbol moves when o_out_valid && i_out_ready at a rising edge;
  // while o_out_valid && !i_out_ready every output holds; i_abort beats both.

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_PRE = 2'd1, S_DATA = 2'd2} state_t;

  localparam int                    N        = PRBS_ORDER;
  localparam logic [N-1:0]          SEED_M   = SEED[N-1:0];
  localparam logic [15:0]           PRE_LAST = 16'(PRE_LEN - 1);
  localparam logic signed [7:0]     AMP8     = 8'(AMP);

  state_t             r_state, w_state_nxt;
  logic [N-1:0]       r_lfsr, w_lfsr_nxt, w_lfsr_a, w_lfsr_b;
  logic [15:0]        r_len, w_len_nxt;
  logic [15:0]        r_cnt, w_cnt_nxt, w_cnt_inc;
  logic               r_valid, w_valid_nxt;
  logic [1:0]         r_sym, w_sym_nxt;
  logic signed [3:0]  r_lvl, w_lvl_nxt;
  logic signed [7:0]  r_s, w_s_nxt;
  logic               r_sof, w_sof_nxt;
  logic               r_eof, w_eof_nxt;
  logic               r_busy;
  logic               r_done, w_done_nxt;
  logic               w_xfer;
  logic [1:0]         w_raw, w_nat;

  function automatic logic [N-1:0] lfsr_step(input logic [N-1:0] l);
    logic nb;
    nb = l[N-1] ^ l[N-2];
    return {l[N-2:0], nb};
  endfunction

  function automatic logic signed [3:0] sym_lvl(input logic [1:0] s);
    case (s)
      2'b00:   return 4'sb1101;
      2'b01:   return 4'sb1111;
      2'b10:   return 4'sb0001;
      default: return 4'sb0011;
    endcase
  endfunction

  assign w_xfer    = r_valid & i_out_ready;
  assign w_cnt_inc = r_cnt + 16'd1;
  // Two LFSR steps per symbol: first new bit is the MSB of the raw pair.
  assign w_lfsr_a  = lfsr_step(r_lfsr);
  assign w_lfsr_b  = lfsr_step(w_lfsr_a);
  assign w_raw     = {w_lfsr_a[0], w_lfsr_b[0]};
  assign w_nat     = GRAY ? {w_raw[1], w_raw[1] ^ w_raw[0]} : w_raw;

  assign w_lvl_nxt = w_valid_nxt ? sym_lvl(w_sym_nxt) : 4'sd0;
  assign w_s_nxt   = $signed({{4{w_lvl_nxt[3]}}, w_lvl_nxt}) * AMP8;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_lfsr  <= SEED_M;
      r_len   <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_sym   <= '0;
      r_lvl   <= '0;
      r_s     <= '0;
      r_sof   <= 1'b0;
      r_eof   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_lfsr  <= w_lfsr_nxt;
      r_len   <= w_len_nxt;
      r_cnt   <= w_cnt_nxt;
      r_valid <= w_valid_nxt;
      r_sym   <= w_sym_nxt;
      r_lvl   <= w_lvl_nxt;
      r_s     <= w_s_nxt;
      r_sof   <= w_sof_nxt;
      r_eof   <= w_eof_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_state_nxt = S_PRE;
      S_PRE:   if (w_xfer && (r_cnt == PRE_LAST))
                 w_state_nxt = (r_len == 16'd0) ? S_IDLE : S_DATA;
      S_DATA:  if (w_xfer && r_eof) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (i_abort) w_state_nxt = S_IDLE;
  end

  always_comb begin
    w_lfsr_nxt  = r_lfsr;
    w_len_nxt   = r_len;
    w_cnt_nxt   = r_cnt;
    w_valid_nxt = r_valid;
    w_sym_nxt   = r_sym;
    w_sof_nxt   = r_sof;
    w_eof_nxt   = r_eof;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: if (i_start) begin
        w_lfsr_nxt  = SEED_M;
        w_len_nxt   = i_len;
        w_cnt_nxt   = '0;
        w_valid_nxt = 1'b1;
        w_sym_nxt   = 2'b11;
        w_sof_nxt   = 1'b1;
        w_eof_nxt   = (PRE_LAST == 16'd0) && (i_len == 16'd0);
      end
      S_PRE: if (w_xfer) begin
        w_sof_nxt = 1'b0;
        if (r_cnt == PRE_LAST) begin
          if (r_len == 16'd0) begin
            w_valid_nxt = 1'b0;
            w_sym_nxt   = '0;
            w_eof_nxt   = 1'b0;
            w_cnt_nxt   = '0;
            w_done_nxt  = 1'b1;
          end else begin
            w_lfsr_nxt = w_lfsr_b;
            w_sym_nxt  = w_nat;
            w_cnt_nxt  = 16'd1;
            w_eof_nxt  = (r_len == 16'd1);
          end
        end else begin
          w_cnt_nxt = w_cnt_inc;
          w_sym_nxt = w_cnt_inc[0] ? 2'b00 : 2'b11;
          w_eof_nxt = (r_len == 16'd0) && (w_cnt_inc == PRE_LAST);
        end
      end
      S_DATA: if (w_xfer) begin
        if (r_eof) begin
          w_valid_nxt = 1'b0;
          w_sym_nxt   = '0;
          w_eof_nxt   = 1'b0;
          w_cnt_nxt   = '0;
          w_done_nxt  = 1'b1;
        end else begin
          w_lfsr_nxt = w_lfsr_b;
          w_sym_nxt  = w_nat;
          w_cnt_nxt  = w_cnt_inc;
          w_eof_nxt  = (w_cnt_inc == r_len);
        end
      end
      default: ;
    endcase
    if (i_abort) begin
      w_valid_nxt = 1'b0;
      w_sym_nxt   = '0;
      w_sof_nxt   = 1'b0;
      w_eof_nxt   = 1'b0;
      w_cnt_nxt   = '0;
      w_done_nxt  = 1'b0;
    end
  end

  assign o_out_valid = r_valid;
  assign o_d_sym     = r_sym;
  assign o_d_lvl     = r_lvl;
  assign o_s_out     = r_s;
  assign o_sof       = r_sof;
  assign o_eof       = r_eof;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_state     = r_state;

endmodule

// File: tb/tb_pam4_prbs_tx.sv
// Bench for pam4_prbs_tx: a natural-mapping and a Gray-mapping instance share
// stimulus; a negedge monitor scores every transfer against expected queues.
module tb_pam4_prbs_tx;

  localparam int PRE_LEN = 8;
  localparam int W       = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] len = '0;

  logic a_valid, a_sof, a_eof, a_busy, a_done;
  logic [1:0] a_sym, a_state;
  logic signed [3:0] a_lvl;
  logic signed [7:0] a_s;
  logic g_valid, g_sof, g_eof, g_busy, g_done;
  logic [1:0] g_sym, g_state;
  logic signed [3:0] g_lvl;
  logic signed [7:0] g_s;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_g_q[$];
  int n_vec = 0, n_err = 0, n_xfer = 0, n_done = 0;
  bit ready_auto = 1'b0, ready_rand = 1'b0;

  pam4_prbs_tx #(.PRBS_ORDER(7), .SEED(15'h007F), .PRE_LEN(PRE_LEN), .GRAY(1'b0), .AMP(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .i_start(start), .i_len(len), .i_abort(abort),
    .o_out_valid(a_valid), .i_out_ready(out_ready), .o_d_sym(a_sym), .o_d_lvl(a_lvl),
    .o_s_out(a_s), .o_sof(a_sof), .o_eof(a_eof), .o_busy(a_busy), .o_done(a_done), .o_state(a_state));

  pam4_prbs_tx #(.PRBS_ORDER(7), .SEED(15'h007F), .PRE_LEN(PRE_LEN), .GRAY(1'b1), .AMP(32)) u_dut_g (
    .clk(clk), .rst_n(rst_n), .i_start(start), .i_len(len), .i_abort(abort),
    .o_out_valid(g_valid), .i_out_ready(out_ready), .o_d_sym(g_sym), .o_d_lvl(g_lvl),
    .o_s_out(g_s), .o_sof(g_sof), .o_eof(g_eof), .o_busy(g_busy), .o_done(g_done), .o_state(g_state));

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d miscompares so far", n_err);
    $fatal(1, "watchdog");
  end

  always @(posedge clk) begin
    #1;
    if (ready_auto) out_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // expected-value model
  function automatic logic [W-1:0] pack(input logic sof, input logic eof, input logic [1:0] sym);
    logic signed [3:0] lvl;
    int s;
    case (sym)
      2'b00:   lvl = -4'sd3;
      2'b01:   lvl = -4'sd1;
      2'b10:   lvl = 4'sd1;
      default: lvl = 4'sd3;
    endcase
    s = int'(lvl) * 32;
    return {sof, eof, sym, lvl, 8'(s)};
  endfunction

  task automatic gen_raw(inout logic [6:0] l, output logic [1:0] raw);
    logic nb;
    for (int k = 1; k >= 0; k--) begin
      nb = l[6] ^ l[5];
      l = {l[5:0], nb};
      raw[k] = nb;
    end
  endtask

  task automatic push_frame(input int n);
    logic [6:0] l;
    logic [1:0] s, gs;
    l = 7'h7F;
    for (int i = 0; i < PRE_LEN; i++) begin
      s = (i % 2 == 0) ? 2'b11 : 2'b00;
      exp_q.push_back(pack(i == 0, (n == 0) && (i == PRE_LEN - 1), s));
      exp_g_q.push_back(pack(i == 0, (n == 0) && (i == PRE_LEN - 1), s));
    end
    for (int i = 1; i <= n; i++) begin
      gen_raw(l, s);
      gs = {s[1], s[1] ^ s[0]};
      exp_q.push_back(pack(1'b0, i == n, s));
      exp_g_q.push_back(pack(1'b0, i == n, gs));
    end
  endtask

  // scoreboard monitor
  logic [W-1:0] held_a, held_g;
  bit prev_stall = 1'b0, exp_done = 1'b0;

  always @(negedge clk) begin
    logic [W-1:0] got_a, got_g, e;
    got_a = {a_sof, a_eof, a_sym, a_lvl, a_s};
    got_g = {g_sof, g_eof, g_sym, g_lvl, g_s};
    if (!rst_n) begin
      prev_stall = 1'b0;
      exp_done = 1'b0;
    end else begin
      if (exp_done || a_done) begin
        n_vec++;
        if (a_done !== exp_done || (exp_done && a_busy !== 1'b0)) begin
          n_err++;
          $display("FAIL done_pulse: got done=%b busy=%b, expected done=%b busy=0", a_done, a_busy, exp_done);
        end
      end
      if (a_done) n_done++;
      exp_done = 1'b0;
      if (prev_stall) begin
        n_vec++;
        if (got_a !== held_a || got_g !== held_g || a_valid !== 1'b1) begin
          n_err++;
          $display("FAIL stall_hold: got %h/%h valid=%b, expected %h/%h valid=1", got_a, got_g, a_valid, held_a, held_g);
        end
      end
      if (a_valid && out_ready && !abort) begin
        n_xfer++;
        if (exp_q.size() == 0 || exp_g_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_symbol: got %h, expected no transfer", got_a);
        end else begin
          e = exp_q.pop_front();
          n_vec++;
          if (got_a !== e) begin
            n_err++;
            $display("FAIL symbol: got {sof,eof,sym,lvl,s}=%h, expected %h", got_a, e);
          end
          e = exp_g_q.pop_front();
          n_vec++;
          if (got_g !== e || g_valid !== 1'b1) begin
            n_err++;
            $display("FAIL gray_symbol: got %h valid=%b, expected %h valid=1", got_g, g_valid, e);
          end
        end
        exp_done = a_eof;
      end
      prev_stall = a_valid && !out_ready && !abort;
      held_a = got_a;
      held_g = got_g;
    end
  end

  // driver tasks
  task automatic pulse_start(input logic [15:0] n);
    @(posedge clk); #1;
    start = 1'b1;
    len = n;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(posedge clk); #2;
      if (exp_q.size() == 0 && !a_valid) break;
    end
    if (i == budget) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: %0d symbols left, expected 0", exp_q.size());
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic wait_xfer(input int target, input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (n_xfer >= target) break;
    end
    if (i == budget) begin
      n_vec++;
      n_err++;
      $display("FAIL xfer_timeout: got %0d transfers, expected %0d", n_xfer, target);
    end
  endtask

  task automatic check_all_zero(input string tag);
    n_vec++;
    if ({a_valid, a_sym, a_lvl, a_s, a_sof, a_eof, a_busy, a_done, a_state} !== '0 ||
        {g_valid, g_sym, g_lvl, g_s, g_sof, g_eof, g_busy, g_done, g_state} !== '0) begin
      n_err++;
      $display("FAIL %s: got valid=%b sym=%b lvl=%0d s=%0d sof=%b eof=%b busy=%b done=%b state=%0d, expected all 0",
               tag, a_valid, a_sym, a_lvl, a_s, a_sof, a_eof, a_busy, a_done, a_state);
    end
  endtask

  // scenarios
  task automatic test_reset();
    ready_auto = 1'b0;
    out_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset_state");
    #2 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("idle_after_reset");
  endtask

  task automatic test_basic();
    ready_auto = 1'b1;
    ready_rand = 1'b0;
    push_frame(4);
    pulse_start(16'd4);
    n_vec++;
    if (a_valid !== 1'b1 || a_sof !== 1'b1 || a_sym !== 2'b11 || a_s !== 8'sd96 || a_busy !== 1'b1) begin
      n_err++;
      $display("FAIL start_latency: got valid=%b sof=%b sym=%b s=%0d busy=%b, expected 1 1 11 96 1",
               a_valid, a_sof, a_sym, a_s, a_busy);
    end
    wait_drain(100);
  endtask

  task automatic test_backpressure();
    ready_auto = 1'b1;
    ready_rand = 1'b1;
    push_frame(4);
    pulse_start(16'd4);
    wait_drain(300);
    push_frame(300);
    pulse_start(16'd300);
    wait_drain(3000);
    ready_rand = 1'b0;
  endtask

  task automatic test_gray();
    int x0;
    ready_auto = 1'b1;
    ready_rand = 1'b0;
    x0 = n_xfer;
    push_frame(4);
    pulse_start(16'd4);
    wait_xfer(x0 + PRE_LEN + 3, 100);
    n_vec++;
    if (g_sym !== 2'b11 || g_lvl !== 4'sd3 || g_s !== 8'sd96 || g_eof !== 1'b1 ||
        a_sym !== 2'b10 || a_lvl !== 4'sd1 || a_s !== 8'sd32) begin
      n_err++;
      $display("FAIL gray_map: got gray sym=%b lvl=%0d s=%0d eof=%b nat sym=%b s=%0d, expected 11 3 96 1 / 10 32",
               g_sym, g_lvl, g_s, g_eof, a_sym, a_s);
    end
    wait_drain(100);
  endtask

  task automatic test_len0();
    int x0, d0;
    ready_auto = 1'b1;
    x0 = n_xfer;
    d0 = n_done;
    push_frame(0);
    pulse_start(16'd0);
    wait_drain(100);
    n_vec++;
    if (n_xfer - x0 != PRE_LEN || n_done - d0 != 1) begin
      n_err++;
      $display("FAIL len0_frame: got %0d symbols %0d done, expected %0d symbols 1 done",
               n_xfer - x0, n_done - d0, PRE_LEN);
    end
  endtask

  task automatic test_abort();
    int x0, d0;
    ready_auto = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    x0 = n_xfer;
    d0 = n_done;
    push_frame(4);
    pulse_start(16'd4);
    wait_xfer(x0 + PRE_LEN + 1, 100);
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    n_vec++;
    if (a_valid !== 1'b0 || a_busy !== 1'b0 || a_state !== 2'd0 || a_eof !== 1'b0) begin
      n_err++;
      $display("FAIL abort_stop: got valid=%b busy=%b state=%0d eof=%b, expected 0 0 0 0", a_valid, a_busy, a_state, a_eof);
    end
    exp_q.delete();
    exp_g_q.delete();
    repeat (5) @(posedge clk);
    #1;
    n_vec++;
    if (n_done != d0) begin
      n_err++;
      $display("FAIL abort_no_done: got %0d done pulses, expected 0", n_done - d0);
    end
    out_ready = 1'b1;
    ready_rand = 1'b0;
    ready_auto = 1'b1;
    push_frame(4);
    pulse_start(16'd4);
    wait_drain(100);
  endtask

  task automatic test_reset_mid();
    int x0;
    ready_auto = 1'b1;
    ready_rand = 1'b0;
    x0 = n_xfer;
    push_frame(6);
    pulse_start(16'd6);
    wait_xfer(x0 + PRE_LEN + 2, 100);
    start = 1'b1;
    len = 16'd1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_xfer(x0 + PRE_LEN + 4, 100);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    exp_q.delete();
    exp_g_q.delete();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check_all_zero("idle_after_mid_reset");
  endtask

  task automatic test_back_to_back();
    int i;
    ready_auto = 1'b1;
    ready_rand = 1'b0;
    push_frame(2);
    push_frame(3);
    pulse_start(16'd2);
    for (i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (a_done) break;
    end
    start = 1'b1;
    len = 16'd3;
    @(posedge clk); #1;
    start = 1'b0;
    n_vec++;
    if (i == 100 || a_valid !== 1'b1 || a_sof !== 1'b1 || a_busy !== 1'b1) begin
      n_err++;
      $display("FAIL start_in_done_cycle: got valid=%b sof=%b busy=%b, expected 1 1 1", a_valid, a_sof, a_busy);
    end
    wait_drain(100);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_gray();
    test_len0();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL leftover: got %0d unconsumed expected symbols, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pam4_prbs_tx.md
Name: pam4_prbs_tx

Overview:
PAM4 test-pattern transmitter that drives the CDR/MMPD receive path in simulation and on the FPGA loopback bench. It emits a start preamble of alternating full-scale symbols, then a PRBS-derived PAM4 symbol stream. Every symbol is presented three ways: the 2-bit symbol, the signed decoded level (±1, ±3), and a signed 8-bit scaled sample. The symbol and level encodings match what the phase detector consumes. Output uses a valid/ready handshake so the channel model can apply backpressure.

Parameters:
PRBS_ORDER, 7, LFSR polynomial select: 7 → x^7+x^6+1, 15 → x^15+x^14+1; any other value is illegal.
SEED, 15'h7FFF, LFSR reload value; only the low PRBS_ORDER bits are used, and they must be nonzero.
PRE_LEN, 8, number of preamble symbols, 1..255.
GRAY, 0, 1 → the raw 2-bit PRBS pair is Gray-decoded before level mapping.
AMP, 32, sample scale; s_out = d_lvl*AMP. 3*AMP must be ≤ 127.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request to begin a frame; sampled only in IDLE
len  in  16  number of PRBS data symbols in the frame; sampled on accepted start
abort  in  1  synchronous stop; return to IDLE
out_valid  out  1  symbol outputs valid
out_ready  in  1  sink accepts the symbol when out_valid && out_ready
d_sym  out  2  PAM4 symbol, 00:-3, 01:-1, 10:+1, 11:+3
d_lvl  out  4  signed decoded level
s_out  out  8  signed sample, d_lvl*AMP
sof  out  1  high with the first preamble symbol
eof  out  1  high with the last symbol of the frame
busy  out  1  high in PRE or DATA
done  out  1  one-cycle pulse after the last symbol transfers

Behaviour:
- Reset state: IDLE, LFSR=SEED, all counters 0, every output 0. s_out, d_lvl and d_sym read 0 while out_valid=0.
- All outputs are registered. A symbol changes only on a transfer (out_valid && out_ready). While out_valid && !out_ready, every output is held stable.
- FSM states: IDLE, PRE, DATA.
- IDLE:
  - start=1 → LFSR reloaded with SEED, len latched, symbol counter cleared, next state PRE.
  - out_valid rises the next cycle (latency 1), carrying preamble symbol 0 with sof=1.
  - start is ignored while busy.
- PRE:
  - Symbols alternate 11, 00, 11, ... starting with 11 (+3, -3, ...).
  - After PRE_LEN transfers: if latched len=0 → IDLE; else → DATA.
  - If latched len=0, the final preamble symbol carries eof=1.
- DATA:
  - Each symbol advances the LFSR twice. One step: nb = lfsr[N-1]^lfsr[N-2]; lfsr <= {lfsr[N-2:0], nb}, where N=PRBS_ORDER.
  - First nb becomes raw[1], second nb becomes raw[0].
  - With GRAY=1: nat = {raw[1], raw[1]^raw[0]}; otherwise nat = raw. d_sym = nat.
  - The LFSR advances only on a transfer, so the sequence is independent of backpressure.
  - The len-th data symbol carries eof=1. Its transfer → IDLE.
- done: pulses 1 cycle in the cycle after the eof transfer. busy is 0 in that cycle. A start in that same cycle is accepted.
- Level map: 00→-3, 01→-1, 10→+1, 11→+3, held as a 4-bit signed value. s_out is d_lvl*AMP computed at 8 bits and never wraps under the AMP constraint.
- abort:
  - Any state → IDLE on the next edge; out_valid drops.
  - No done pulse, no eof.
  - abort has priority over a simultaneous transfer and over start.
- rst_n low at any time: immediate return to the reset state, including mid-frame and mid-stall.
- The symbol counter is 16 bits; len=65535 must complete without wrap.

Test Plan:
1. Reset, then start with len=4, PRBS_ORDER=7, SEED=7'h7F, GRAY=0, AMP=32, ready=1 → 8 preamble symbols +96/-96 alternating, sof on the first. Data d_sym = 00, 00, 00, 10, with s_out = -96, -96, -96, +32. eof on the 4th data symbol, done the next cycle.
2. Same frame with out_ready toggling pseudo-randomly → identical symbol sequence. Outputs are stable during every stall.
3. GRAY=1, same seed → 4th data symbol raw 10 maps to nat 11, d_lvl=+3, s_out=+96.
4. len=0 → exactly PRE_LEN symbols; the last preamble symbol has eof=1; done pulses once.
5. abort during data symbol 2 while stalled → out_valid=0 on the next cycle, no done. A following start restarts the frame from SEED and reproduces scenario 1's sequence.
6. rst_n asserted mid-DATA, plus a start pulse issued while busy → all outputs 0 immediately on reset; the start issued while busy has no effect.
